// File: rtl/game_round_controller_pkg.sv
// Shared types and defaults for the game round controller and timer.
// Level/lives defaults are also used by the timer's level table.
package game_pkg;

  localparam int LEVEL_W = 3;
  localparam int DEF_MAX_LEVEL = 5;
  localparam int DEF_START_LIVES = 3;

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    ARM,
    RUN,
    WIN,
    LOSE,
    LOST,
    WON
  } state_e;

endpackage

// File: rtl/game_round_controller_if.sv
// Command/status bundle between the round controller and the
// countdown timer.
interface game_round_controller_if;
  import game_pkg::*;

  logic               timerReconfig;
  logic               timerEnable;
  logic [LEVEL_W-1:0] gameLevel;
  logic               timeout;

  modport master (
    output timerReconfig,
    output timerEnable,
    output gameLevel,
    input  timeout
  );

  modport slave (
    input  timerReconfig,
    input  timerEnable,
    input  gameLevel,
    output timeout
  );

endinterface

// File: rtl/game_round_controller_score.sv
// Saturating score accumulator with synchronous clear and
// add-enable.
module score_accum #(
  parameter int SCORE_W = 8,
  parameter int ADD_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add_en,
  input  logic [ADD_W-1:0]   add,
  output logic [SCORE_W-1:0] score
);

  logic [SCORE_W:0] sum;

  assign sum = {1'b0, score} + (SCORE_W+1)'(add);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      score <= '0;
    end else if (add_en) begin
      score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/game_round_controller.sv
// Round/level/lives sequencer; master of the countdown timer's
// command interface. All outputs are registered.
module game_round_controller
  import game_pkg::*;
#(
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int START_LIVES = DEF_START_LIVES,
  parameter int SCORE_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    startPulse,
  input  logic                    correctPulse,
  input  logic                    wrongPulse,
  game_round_controller_if.master tmr,
  output logic [2:0]              lives,
  output logic [SCORE_W-1:0]      score,
  output logic                    roundActive,
  output logic                    gameOver,
  output logic                    gameWon
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_CONFIG = CONFIG;
  localparam logic [2:0] S_ARM    = ARM;
  localparam logic [2:0] S_RUN    = RUN;
  localparam logic [2:0] S_WIN    = WIN;
  localparam logic [2:0] S_LOSE   = LOSE;
  localparam logic [2:0] S_LOST   = LOST;
  localparam logic [2:0] S_WON    = WON;

  localparam logic [LEVEL_W-1:0] MAX_LV = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LV_ONE = LEVEL_W'(1);
  localparam logic [2:0]         LIVES0 = 3'(START_LIVES);

  logic [2:0] state;
  logic [2:0] nxt;
  logic       start_game;
  logic       in_win;

  assign start_game = startPulse &&
    (state == S_IDLE || state == S_LOST || state == S_WON);
  assign in_win = (state == S_WIN);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_LOST, S_WON:
        if (startPulse) nxt = S_CONFIG;
      S_CONFIG: nxt = S_ARM;
      S_ARM:    nxt = S_RUN;
      // a late answer loses to a timeout; both answers count as wrong
      S_RUN: begin
        if (tmr.timeout || wrongPulse) nxt = S_LOSE;
        else if (correctPulse)         nxt = S_WIN;
      end
      S_WIN:
        nxt = (tmr.gameLevel == MAX_LV) ? S_WON : S_CONFIG;
      S_LOSE:
        nxt = (lives == 3'd1) ? S_LOST : S_CONFIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      tmr.timerReconfig <= 1'b0;
      tmr.timerEnable   <= 1'b0;
      tmr.gameLevel     <= LV_ONE;
      lives             <= LIVES0;
      roundActive       <= 1'b0;
      gameOver          <= 1'b0;
      gameWon           <= 1'b0;
    end else begin
      state             <= nxt;
      tmr.timerReconfig <= (nxt == S_CONFIG);
      tmr.timerEnable   <= (nxt == S_RUN);
      roundActive       <= (nxt == S_RUN);
      gameOver          <= (nxt == S_LOST) || (nxt == S_WON);
      gameWon           <= (nxt == S_WON);
      if (start_game) begin
        tmr.gameLevel <= LV_ONE;
        lives         <= LIVES0;
      end
      if (in_win && tmr.gameLevel != MAX_LV)
        tmr.gameLevel <= tmr.gameLevel + LV_ONE;
      if (state == S_LOSE)
        lives <= lives - 3'd1;
    end
  end

  score_accum #(
    .SCORE_W (SCORE_W),
    .ADD_W   (LEVEL_W)
  ) u_score (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_game),
    .add_en (in_win),
    .add    (tmr.gameLevel),
    .score  (score)
  );

endmodule

// File: tb/tb_game_round_controller.sv
// Scenario bench for game_round_controller with a round-level
// reference model of level, lives, score and outcome.
module tb_game_round_controller;
  import game_pkg::*;

  localparam int MAXL = 5;
  localparam int SL   = 3;
  localparam int SW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          startPulse;
  logic          correctPulse;
  logic          wrongPulse;
  logic [2:0]    lives;
  logic [SW-1:0] score;
  logic          roundActive;
  logic          gameOver;
  logic          gameWon;

  game_round_controller_if tif();

  game_round_controller #(
    .MAX_LEVEL   (MAXL),
    .START_LIVES (SL),
    .SCORE_W     (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .startPulse   (startPulse),
    .correctPulse (correctPulse),
    .wrongPulse   (wrongPulse),
    .tmr          (tif),
    .lives        (lives),
    .score        (score),
    .roundActive  (roundActive),
    .gameOver     (gameOver),
    .gameWon      (gameWon)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // game-level model: one update per resolved round
  int m_level;
  int m_lives;
  int m_score;
  bit m_won;
  bit m_lost;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    startPulse   = 1'b0;
    correctPulse = 1'b0;
    wrongPulse   = 1'b0;
    tif.timeout  = 1'b0;
  endtask

  task automatic model_start();
    m_level = 1;
    m_lives = SL;
    m_score = 0;
    m_won   = 1'b0;
    m_lost  = 1'b0;
  endtask

  // ev: 0 correct, 1 wrong, 2 timeout, 3 timeout+correct, 4 correct+wrong
  task automatic model_event(input int ev);
    if (ev == 0) begin
      m_score = m_score + m_level;
      if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
      if (m_level == MAXL) m_won = 1'b1;
      else m_level++;
    end else begin
      m_lives--;
      if (m_lives == 0) m_lost = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // start and advance to RUN; caller is left in RUN
  task automatic start_to_run();
    startPulse = 1'b1;
    tick();
    startPulse = 1'b0;
    model_start();
    tick();
    tick();
    n_checks++;
    if (tif.timerEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL run_entry: timerEnable=%b want 1", tif.timerEnable);
    end
  endtask

  // one round from RUN; returns in RUN or in a game-over state
  task automatic play_round(input int ev, input int dly);
    for (int i = 0; i < dly; i++) tick();
    tif.timeout  = (ev == 2 || ev == 3);
    correctPulse = (ev == 0 || ev == 3 || ev == 4);
    wrongPulse   = (ev == 1 || ev == 4);
    tick();
    correctPulse = 1'b0;
    wrongPulse   = 1'b0;
    model_event(ev);
    n_checks++;
    if (tif.timerEnable !== 1'b0 || roundActive !== 1'b0 ||
        tif.timerReconfig !== 1'b0) begin
      n_fail++;
      $display("FAIL resolve_cycle ev=%0d: en=%b act=%b rcfg=%b want 0 0 0",
               ev, tif.timerEnable, roundActive, tif.timerReconfig);
    end
    tick();
    n_checks++;
    if (lives !== 3'(m_lives) || score !== SW'(m_score) ||
        tif.gameLevel !== 3'(m_level)) begin
      n_fail++;
      $display("FAIL round_state ev=%0d: lv=%0d lives=%0d score=%0d want %0d %0d %0d",
               ev, tif.gameLevel, lives, score, m_level, m_lives, m_score);
    end
    if (m_won || m_lost) begin
      n_checks++;
      if (gameOver !== 1'b1 || gameWon !== m_won ||
          tif.timerEnable !== 1'b0 || tif.timerReconfig !== 1'b0) begin
        n_fail++;
        $display("FAIL game_end: over=%b won=%b en=%b rcfg=%b want 1 %b 0 0",
                 gameOver, gameWon, tif.timerEnable, tif.timerReconfig, m_won);
      end
      tif.timeout = 1'b0;
    end else begin
      n_checks++;
      if (tif.timerReconfig !== 1'b1 || gameOver !== 1'b0) begin
        n_fail++;
        $display("FAIL reconfig_after_event: rcfg=%b over=%b want 1 0",
                 tif.timerReconfig, gameOver);
      end
      tif.timeout = 1'b0;
      tick();
      n_checks++;
      if (tif.timerReconfig !== 1'b0 || tif.timerEnable !== 1'b0) begin
        n_fail++;
        $display("FAIL arm_cycle: rcfg=%b en=%b want 0 0",
                 tif.timerReconfig, tif.timerEnable);
      end
      tick();
      n_checks++;
      if (tif.timerEnable !== 1'b1 || roundActive !== 1'b1) begin
        n_fail++;
        $display("FAIL rerun: en=%b act=%b want 1 1",
                 tif.timerEnable, roundActive);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (tif.timerReconfig !== 1'b0 || tif.timerEnable !== 1'b0 ||
        tif.gameLevel !== 3'd1 || lives !== 3'd3 || score !== '0 ||
        roundActive !== 1'b0 || gameOver !== 1'b0 || gameWon !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: rcfg=%b en=%b lv=%0d lives=%0d score=%0d act=%b over=%b won=%b",
               tif.timerReconfig, tif.timerEnable, tif.gameLevel, lives,
               score, roundActive, gameOver, gameWon);
    end
  endtask

  task automatic test_start();
    do_reset();
    startPulse = 1'b1;
    tick();
    startPulse = 1'b0;
    n_checks++;
    if (tif.timerReconfig !== 1'b1 || tif.timerEnable !== 1'b0 ||
        tif.gameLevel !== 3'd1) begin
      n_fail++;
      $display("FAIL start_plus1: rcfg=%b en=%b lv=%0d want 1 0 1",
               tif.timerReconfig, tif.timerEnable, tif.gameLevel);
    end
    tick();
    n_checks++;
    if (tif.timerReconfig !== 1'b0 || tif.timerEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL start_plus2: rcfg=%b en=%b want 0 0",
               tif.timerReconfig, tif.timerEnable);
    end
    tick();
    n_checks++;
    if (tif.timerEnable !== 1'b1 || roundActive !== 1'b1 ||
        lives !== 3'd3 || score !== '0) begin
      n_fail++;
      $display("FAIL start_plus3: en=%b act=%b lives=%0d score=%0d want 1 1 3 0",
               tif.timerEnable, roundActive, lives, score);
    end
  endtask

  task automatic test_full_win();
    do_reset();
    start_to_run();
    for (int l = 1; l <= MAXL; l++) play_round(0, l % 3);
    n_checks++;
    if (score !== 8'd15 || gameWon !== 1'b1 || gameOver !== 1'b1 ||
        tif.timerEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL full_win: score=%0d won=%b over=%b en=%b want 15 1 1 0",
               score, gameWon, gameOver, tif.timerEnable);
    end
  endtask

  task automatic test_timeout_losses();
    do_reset();
    start_to_run();
    play_round(0, 0);
    for (int k = 0; k < 3; k++) play_round(2, 1);
    n_checks++;
    if (lives !== 3'd0 || tif.gameLevel !== 3'd2 || gameOver !== 1'b1 ||
        gameWon !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_lost: lives=%0d lv=%0d over=%b won=%b want 0 2 1 0",
               lives, tif.gameLevel, gameOver, gameWon);
    end
  endtask

  // restarts straight out of LOST
  task automatic test_simultaneous();
    start_to_run();
    play_round(3, 0);
    n_checks++;
    if (lives !== 3'd2 || score !== '0) begin
      n_fail++;
      $display("FAIL timeout_plus_correct: lives=%0d score=%0d want 2 0",
               lives, score);
    end
    play_round(4, 2);
    n_checks++;
    if (lives !== 3'd1 || score !== '0 || tif.gameLevel !== 3'd1) begin
      n_fail++;
      $display("FAIL correct_plus_wrong: lives=%0d score=%0d lv=%0d want 1 0 1",
               lives, score, tif.gameLevel);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    correctPulse = 1'b1;
    wrongPulse   = 1'b1;
    tif.timeout  = 1'b1;
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (score !== '0 || lives !== 3'd3 || tif.timerReconfig !== 1'b0 ||
        roundActive !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: score=%0d lives=%0d rcfg=%b act=%b want 0 3 0 0",
               score, lives, tif.timerReconfig, roundActive);
    end
    startPulse = 1'b1;
    tick();
    startPulse  = 1'b0;
    tif.timeout = 1'b1;
    tick();
    tick();
    tif.timeout = 1'b0;
    tick();
    n_checks++;
    if (tif.timerEnable !== 1'b1 || lives !== 3'd3) begin
      n_fail++;
      $display("FAIL stale_timeout: en=%b lives=%0d want 1 3",
               tif.timerEnable, lives);
    end
    startPulse = 1'b1;
    tick();
    startPulse = 1'b0;
    tick();
    n_checks++;
    if (tif.timerEnable !== 1'b1 || tif.timerReconfig !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_run: en=%b rcfg=%b want 1 0",
               tif.timerEnable, tif.timerReconfig);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_to_run();
    play_round(0, 0);
    play_round(0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (tif.timerEnable !== 1'b0 || tif.gameLevel !== 3'd1 ||
        score !== '0 || lives !== 3'd3 || roundActive !== 1'b0 ||
        tif.timerReconfig !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: en=%b lv=%0d score=%0d lives=%0d act=%b rcfg=%b",
               tif.timerEnable, tif.gameLevel, score, lives, roundActive,
               tif.timerReconfig);
    end
  endtask

  task automatic test_random();
    for (int g = 0; g < 6; g++) begin
      do_reset();
      start_to_run();
      for (int r = 0; r < 40 && !(m_won || m_lost); r++) begin
        int pick;
        pick = $urandom_range(0, 9);
        play_round((pick < 5) ? 0 : pick - 5, $urandom_range(0, 3));
      end
      n_checks++;
      if (gameOver !== 1'b1 || gameWon !== m_won) begin
        n_fail++;
        $display("FAIL random_game %0d: over=%b won=%b want 1 %b",
                 g, gameOver, gameWon, m_won);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_start();
    test_full_win();
    test_timeout_losses();
    test_simultaneous();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
Master-side sequencer for the two-digit countdown timer. It owns the timer's command interface: it drives the timerReconfig, timerEnable and gameLevel inputs, and it consumes the timer's timeout output. It runs the round/level/lives flow of the game, sitting between the player-input conditioning logic and the timer/display path.

Parameters:
MAX_LEVEL, 5, highest playable level (1..7); clearing this level ends the game as won
START_LIVES, 3, lives loaded at game start (1..7)
SCORE_W, 8, score register width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
startPulse  in  1  one-cycle request to start a new game
correctPulse  in  1  one-cycle: player answered correctly
wrongPulse  in  1  one-cycle: player answered incorrectly
timeout  in  1  level signal from the timer: count reached 00
timerReconfig  out  1  one-cycle load strobe to the timer
timerEnable  out  1  timer count enable
gameLevel  out  3  level presented to the timer; stable whenever timerReconfig=1
lives  out  3  remaining lives
score  out  SCORE_W  accumulated score, saturating
roundActive  out  1  high only in RUN
gameOver  out  1  high in LOST or WON
gameWon  out  1  high in WON

Behaviour:
- All registers update on the rising edge of clk. rst is synchronous, active-high, and takes priority over every other input.
- Reset values: state=IDLE, timerReconfig=0, timerEnable=0, gameLevel=1, lives=START_LIVES, score=0, roundActive=0, gameOver=0, gameWon=0.
- All outputs are registered (Moore outputs decoded from the registered state/next-state). There is no combinational path from any input to any output.
- States and transitions:
  - IDLE: waits for startPulse. On startPulse: gameLevel=1, lives=START_LIVES, score=0, then go to CONFIG.
  - CONFIG: timerReconfig=1 for exactly this one cycle, timerEnable=0. Go to ARM.
  - ARM: one settle cycle so the timer can load. timerEnable stays 0. Go to RUN.
  - RUN: timerEnable=1, roundActive=1. Exits are decided in priority order:
    1. timeout=1 takes precedence over a correct answer arriving in the same cycle (the answer was too late). Go to LOSE.
    2. wrongPulse=1 goes to LOSE. wrongPulse and correctPulse together count as wrong.
    3. correctPulse=1 goes to WIN.
  - WIN (1 cycle): timerEnable=0. score += gameLevel, saturating at 2^SCORE_W-1. If gameLevel==MAX_LEVEL go to WON; otherwise gameLevel+1 and go to CONFIG.
  - LOSE (1 cycle): timerEnable=0, lives-1. If lives was 1 go to LOST (lives ends at 0); otherwise go to CONFIG with gameLevel unchanged (the level is replayed).
  - LOST / WON: gameOver=1; gameWon=1 in WON only. timerEnable=0. On startPulse, restart exactly as from IDLE.
- Latency:
  - startPulse in IDLE: timerReconfig is high 1 cycle later, timerEnable high 3 cycles later.
  - correct/timeout in RUN: timerEnable low the next cycle; the next timerReconfig follows 2 cycles after the event.
- Inputs outside their valid state are ignored:
  - timeout, correctPulse, wrongPulse outside RUN.
  - startPulse outside IDLE/LOST/WON (no restart mid-game).
- The timer deasserts timeout on reconfig. The controller never samples timeout in CONFIG or ARM, so a stale timeout left over from the previous round is harmless.
- gameLevel never exceeds MAX_LEVEL and never equals 0.
- Reset asserted mid-round: next cycle is IDLE with reset values; timerEnable drops in that same cycle.

Decomposition:
- Shared package game_pkg:
  - State encoding enum: IDLE, CONFIG, ARM, RUN, WIN, LOSE, LOST, WON.
  - LEVEL_W=3.
  - Default MAX_LEVEL and START_LIVES constants, shared with the timer's level table.
- Sub-module: score_accum (saturating adder plus register, with clear and add-enable), instantiated once. Everything else lives in the single FSM module.

Test Plan:
- Reset/start: hold rst 2 cycles, release, pulse startPulse.
  -> timerReconfig=1 on cycle +1 only; gameLevel=1; timerEnable=1 from cycle +3; lives=3, score=0.
- Full win: after each RUN entry, pulse correctPulse (levels 1..5).
  -> gameLevel steps 1,2,3,4,5; score ends at 15; gameWon=1, gameOver=1, timerEnable=0.
- Timeout losses at level 2: raise timeout in RUN three times.
  -> lives 3→2→1→0; gameLevel stays 2; each retry issues one timerReconfig; LOST after the third.
- Simultaneous events in RUN at level 1:
  - timeout and correctPulse together -> LOSE, lives 3→2, score unchanged.
  - correctPulse and wrongPulse together -> LOSE.
- Ignored inputs:
  - timeout=1 during CONFIG/ARM -> no state change.
  - startPulse during RUN -> no restart.
  - correctPulse in IDLE -> score stays 0.
- Reset mid-round at level 3, score 3 -> next cycle: IDLE, timerEnable=0, gameLevel=1, score=0, lives=3.
